branch_resolve_ctrl: RTL and testbench
======================================

Name: branch_resolve_ctrl

Overview:
- Branch resolution controller for the EX stage.
- Sequences the branch comparator on conditional branches and jumps, compares the outcome with the fetch-time prediction, and issues a one-cycle PC redirect plus a multi-cycle IF/ID flush on mispredict.
- Owns a bimodal 2-bit branch history table (BHT): combinational lookup from IF, update from EX.
- Keeps branch and mispredict statistics counters.

Parameters:
- BHT_DEPTH, 64, BHT entries; power of 2, at least 2.
- FLUSH_CYCLES, 2, cycles o_flush stays high per mispredict; range 1..15.
- CNT_W, 32, width of the statistics counters.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_if_pc  in  32  fetch PC for the prediction lookup.
- o_pred_taken  out  1  prediction for i_if_pc; combinational from the BHT.
- i_ex_valid  in  1  EX stage holds a valid instruction.
- i_ex_branch  in  1  EX instruction is a conditional branch.
- i_ex_jump  in  1  EX instruction is JAL/JALR (always taken).
- i_ex_func3  in  3  branch func3.
- i_ex_rs1  in  32  forwarded rs1 value.
- i_ex_rs2  in  32  forwarded rs2 value.
- i_ex_pc  in  32  PC of the EX instruction.
- i_ex_target  in  32  computed taken target.
- i_ex_pred_taken  in  1  prediction carried down the pipeline with the instruction.
- i_stall  in  1  pipeline stall; EX is frozen.
- o_redirect  out  1  one-cycle redirect pulse to IF.
- o_redirect_pc  out  32  correct next PC, valid while o_redirect is high.
- o_flush  out  1  squash IF/ID.
- o_branch_cnt  out  CNT_W  number of resolved branches and jumps.
- o_mispredict_cnt  out  CNT_W  number of mispredicts.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst_n is asynchronous, active-low.
- Reset values: o_redirect=0, o_redirect_pc=0, o_flush=0, both counters=0, every BHT entry=2'b01 (weakly not-taken), FSM=IDLE, flush counter=0.
- Reset is honoured at any time, including mid-flush. Everything returns to reset values immediately.
- Comparator semantics, per func3:
  - BEQ: rs1==rs2.
  - BNE: rs1!=rs2.
  - BLT: signed rs1<rs2, strictly.
  - BGE: signed rs1>=rs2.
  - BLTU: unsigned rs1<rs2, strictly.
  - BGEU: unsigned rs1>=rs2.
  - func3 010/011 are illegal: result=0.
- Resolve event: FSM==IDLE && i_ex_valid && !i_stall && (i_ex_branch || i_ex_jump).
  - If i_ex_branch and i_ex_jump are both high, the jump takes priority.
- Outcome: taken = i_ex_jump | (i_ex_branch & cmp).
- Mispredict: mispredict = (taken != i_ex_pred_taken).
- On a resolve event, at the next rising edge (latency 1):
  - o_branch_cnt increments, except for illegal-func3 branches.
  - If mispredict:
    - o_mispredict_cnt increments.
    - o_redirect pulses high for exactly 1 cycle.
    - o_redirect_pc = taken ? i_ex_target : i_ex_pc+4, with 32-bit wrap.
    - o_flush is high starting in the same cycle, for FLUSH_CYCLES cycles.
    - FSM goes to FLUSH.
- BHT update: on a resolve event of a legal conditional branch only. Jumps and illegal func3 do not update it.
  - Index = i_ex_pc[log2(BHT_DEPTH)+1:2].
  - Taken: saturating increment, capped at 2'b11.
  - Not taken: saturating decrement, floored at 2'b00.
- BHT lookup: index = i_if_pc[log2(BHT_DEPTH)+1:2]; o_pred_taken = entry[1].
  - No bypass: a lookup in the same cycle as an update to the same index returns the pre-update value.
- FSM:
  - IDLE -> FLUSH on a mispredict resolve. Load the flush counter with FLUSH_CYCLES-1.
  - FLUSH: decrement the counter each cycle. When it reaches 0, go to IDLE, and o_flush drops in the following cycle.
  - i_stall does not pause the flush count.
  - While in FLUSH, EX inputs are wrong-path: no resolve, no BHT update, no count.
- Stall: with i_stall high there is no resolve. The same instruction resolves exactly once, after the stall releases.
- Correct prediction: no redirect and no flush. BHT and o_branch_cnt update only.
- Counters wrap modulo 2^CNT_W.
- Back-to-back resolves in consecutive IDLE cycles are each handled independently.

Decomposition:
- Shared header parameters.vh carries:
  - func3 constants BEQ/BNE/BLT/BGE/BLTU/BGEU.
  - FSM state encodings ST_IDLE/ST_FLUSH.
  - BHT reset value 2'b01.
- One sub-module, branch_cmp: purely combinational. Inputs rs1, rs2, func3; output cmp. Semantics as listed above.
- Keep BHT storage and FSM inline in branch_resolve_ctrl.

Test Plan:
- BEQ, rs1=rs2=0x5, pred=0, pc=0x100, target=0x180:
  - Next cycle o_redirect=1 for 1 cycle, o_redirect_pc=0x180.
  - o_flush high 2 cycles.
  - o_mispredict_cnt=1, o_branch_cnt=1.
- Comparator, each case with pred=0:
  - BLT 0xFFFFFFFF vs 0x1 -> taken.
  - BLTU same operands -> not taken, no redirect.
  - BLT 7 vs 7 -> not taken.
  - BGE 7 vs 7 -> taken.
- BHT training at pc=0x200:
  - Reset: lookup 0x200 gives o_pred_taken=0.
  - After 1 taken resolve: o_pred_taken=1.
  - After 5 taken: entry=11. Two not-taken then give entry=01 and o_pred_taken=0.
- JAL with pred=1: no redirect, o_branch_cnt+1, BHT unchanged.
  - Then a taken BNE presented during FLUSH: ignored, counters unchanged.
- i_stall held 3 cycles with a mispredicting branch in EX: no redirect during the stall; exactly one redirect 1 cycle after release.
- Async reset during the second o_flush cycle: o_flush=0 and counters=0 immediately, BHT lookups return 0, FSM is IDLE.

Source files
------------

// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared constants for branch resolution: func3 codes, FSM states, BHT reset value.
// Pure declarations; no timing or flow control.
package branch_resolve_ctrl_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] BHT_RST = 2'b01;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  function automatic logic f3_legal(input logic [2:0] f3);
    return !((f3 == 3'b010) || (f3 == 3'b011));
  endfunction

endpackage

// File: rtl/branch_resolve_ctrl_if.sv
// IF/EX-side bus of the branch resolve controller.
// Carries fetch lookup, EX operands, redirect/flush and statistics; no handshake.
interface branch_resolve_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      i_if_pc;
  logic             o_pred_taken;
  logic             i_ex_valid;
  logic             i_ex_branch;
  logic             i_ex_jump;
  logic [2:0]       i_ex_func3;
  logic [31:0]      i_ex_rs1;
  logic [31:0]      i_ex_rs2;
  logic [31:0]      i_ex_pc;
  logic [31:0]      i_ex_target;
  logic             i_ex_pred_taken;
  logic             i_stall;
  logic             o_redirect;
  logic [31:0]      o_redirect_pc;
  logic             o_flush;
  logic [CNT_W-1:0] o_branch_cnt;
  logic [CNT_W-1:0] o_mispredict_cnt;

  modport slave (
    input  i_if_pc, i_ex_valid, i_ex_branch, i_ex_jump, i_ex_func3,
           i_ex_rs1, i_ex_rs2, i_ex_pc, i_ex_target, i_ex_pred_taken, i_stall,
    output o_pred_taken, o_redirect, o_redirect_pc, o_flush,
           o_branch_cnt, o_mispredict_cnt
  );

  modport master (
    output i_if_pc, i_ex_valid, i_ex_branch, i_ex_jump, i_ex_func3,
           i_ex_rs1, i_ex_rs2, i_ex_pc, i_ex_target, i_ex_pred_taken, i_stall,
    input  o_pred_taken, o_redirect, o_redirect_pc, o_flush,
           o_branch_cnt, o_mispredict_cnt
  );

endinterface

// File: rtl/branch_resolve_ctrl_branch_cmp.sv
// Branch comparator: evaluates the func3 condition on rs1/rs2, purely combinational.
// Zero latency; illegal func3 codes yield not-taken.
module branch_cmp
  import branch_resolve_ctrl_pkg::*;
(
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  input  logic [2:0]  func3_i,
  output logic        cmp_o
);

  always_comb begin
    cmp_o = 1'b0;
    case (func3_i)
      F3_BEQ:  cmp_o = (rs1_i == rs2_i);
      F3_BNE:  cmp_o = (rs1_i != rs2_i);
      F3_BLT:  cmp_o = ($signed(rs1_i) <  $signed(rs2_i));
      F3_BGE:  cmp_o = ($signed(rs1_i) >= $signed(rs2_i));
      F3_BLTU: cmp_o = (rs1_i <  rs2_i);
      F3_BGEU: cmp_o = (rs1_i >= rs2_i);
      default: cmp_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// EX-stage branch resolution: bimodal BHT, 1-cycle redirect, FLUSH_CYCLES-long flush.
// No backpressure; i_stall defers resolve, and wrong-path EX is ignored while flushing.
module branch_resolve_ctrl
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int BHT_DEPTH    = 64,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  branch_resolve_ctrl_if.slave  bus
);

  localparam int         IDX_W      = $clog2(BHT_DEPTH);
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t           state_q, state_d;
  logic [3:0]       fcnt_q, fcnt_d;
  logic [1:0]       bht_q [BHT_DEPTH];
  logic [1:0]       bht_cur, bht_d;
  logic             redirect_q;
  logic [31:0]      redirect_pc_q;
  logic [CNT_W-1:0] bcnt_q, mcnt_q;

  logic             cmp, resolve, legal_br, counted, taken, mispredict, bht_we;
  logic [IDX_W-1:0] upd_idx, lk_idx;

  branch_cmp u_cmp (
    .rs1_i   (bus.i_ex_rs1),
    .rs2_i   (bus.i_ex_rs2),
    .func3_i (bus.i_ex_func3),
    .cmp_o   (cmp)
  );

  assign resolve    = (state_q == ST_IDLE) && bus.i_ex_valid && !bus.i_stall &&
                      (bus.i_ex_branch || bus.i_ex_jump);
  // A jump wins over a simultaneously flagged branch, so it never counts as a branch here.
  assign legal_br   = !bus.i_ex_jump && bus.i_ex_branch && f3_legal(bus.i_ex_func3);
  assign counted    = bus.i_ex_jump || legal_br;
  assign taken      = bus.i_ex_jump || (bus.i_ex_branch && cmp);
  assign mispredict = (taken != bus.i_ex_pred_taken);
  assign bht_we     = resolve && legal_br;

  assign upd_idx = bus.i_ex_pc[IDX_W+1:2];
  assign lk_idx  = bus.i_if_pc[IDX_W+1:2];
  assign bht_cur = bht_q[upd_idx];

  always_comb begin
    bht_d = bht_cur;
    if (taken) begin
      if (bht_cur != 2'b11) bht_d = bht_cur + 2'b01;
    end else begin
      if (bht_cur != 2'b00) bht_d = bht_cur - 2'b01;
    end
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (resolve && mispredict) begin
          state_d = ST_FLUSH;
          fcnt_d  = FLUSH_LOAD;
        end
      end
      ST_FLUSH: begin
        if (fcnt_q == 4'd0) state_d = ST_IDLE;
        else                fcnt_d  = fcnt_q - 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= ST_IDLE;
      fcnt_q        <= 4'd0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= 32'd0;
      bcnt_q        <= '0;
      mcnt_q        <= '0;
    end else begin
      state_q    <= state_d;
      fcnt_q     <= fcnt_d;
      redirect_q <= resolve && mispredict;
      if (resolve && mispredict) begin
        redirect_pc_q <= taken ? bus.i_ex_target : bus.i_ex_pc + 32'd4;
        mcnt_q        <= mcnt_q + CNT_W'(1);
      end
      if (resolve && counted) bcnt_q <= bcnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= BHT_RST;
    end else if (bht_we) begin
      bht_q[upd_idx] <= bht_d;
    end
  end

  assign bus.o_pred_taken     = bht_q[lk_idx][1];
  assign bus.o_redirect       = redirect_q;
  assign bus.o_redirect_pc    = redirect_pc_q;
  assign bus.o_flush          = (state_q == ST_FLUSH);
  assign bus.o_branch_cnt     = bcnt_q;
  assign bus.o_mispredict_cnt = mcnt_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl: directed cases plus randomized traffic
// compared every cycle against a behavioural model.
module tb_branch_resolve_ctrl;

  localparam int BHT_DEPTH    = 64;
  localparam int FLUSH_CYCLES = 2;
  localparam int CNT_W        = 32;
  localparam int IDX_W        = $clog2(BHT_DEPTH);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_resolve_ctrl_if #(.CNT_W(CNT_W)) bus ();

  branch_resolve_ctrl #(
    .BHT_DEPTH    (BHT_DEPTH),
    .FLUSH_CYCLES (FLUSH_CYCLES),
    .CNT_W        (CNT_W)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: counters, a saturating 0..3 table, and a flush countdown.
  int          m_bht [BHT_DEPTH];
  int          m_left;
  bit          m_redir;
  logic [31:0] m_rpc, m_bc, m_mc;

  function automatic bit ref_cmp(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) <  $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a <  b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) m_bht[i] = 1;
      m_left = 0; m_redir = 0; m_rpc = 0; m_bc = 0; m_mc = 0;
    end else begin
      bit busy, tk, legal;
      int idx;
      busy    = (m_left > 0);
      m_redir = 0;
      if (busy) m_left--;
      if (!busy && bus.i_ex_valid && !bus.i_stall && (bus.i_ex_branch || bus.i_ex_jump)) begin
        legal = bus.i_ex_jump || (bus.i_ex_func3 != 3'd2 && bus.i_ex_func3 != 3'd3);
        tk    = bus.i_ex_jump || ref_cmp(bus.i_ex_func3, bus.i_ex_rs1, bus.i_ex_rs2);
        if (legal) m_bc++;
        if (!bus.i_ex_jump && legal) begin
          idx = int'(bus.i_ex_pc[IDX_W+1:2]);
          if (tk) m_bht[idx] = (m_bht[idx] == 3) ? 3 : m_bht[idx] + 1;
          else    m_bht[idx] = (m_bht[idx] == 0) ? 0 : m_bht[idx] - 1;
        end
        if (tk != bus.i_ex_pred_taken) begin
          m_mc++;
          m_redir = 1;
          m_rpc   = tk ? bus.i_ex_target : bus.i_ex_pc + 32'd4;
          m_left  = FLUSH_CYCLES;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      check("redirect", {31'd0, bus.o_redirect}, {31'd0, m_redir});
      if (m_redir) check("redirect_pc", bus.o_redirect_pc, m_rpc);
      check("flush", {31'd0, bus.o_flush}, {31'd0, (m_left > 0)});
      check("branch_cnt", bus.o_branch_cnt, m_bc);
      check("mispredict_cnt", bus.o_mispredict_cnt, m_mc);
      check("pred_taken", {31'd0, bus.o_pred_taken},
            {31'd0, (m_bht[int'(bus.i_if_pc[IDX_W+1:2])] >= 2)});
    end
  end

  task automatic idle_in();
    bus.i_ex_valid = 0; bus.i_ex_branch = 0; bus.i_ex_jump = 0; bus.i_ex_func3 = 3'd0;
    bus.i_ex_rs1 = 0; bus.i_ex_rs2 = 0; bus.i_ex_pc = 0; bus.i_ex_target = 0;
    bus.i_ex_pred_taken = 0; bus.i_stall = 0;
  endtask

  task automatic set_ex(input bit br, input bit jp, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] pc, input logic [31:0] tgt,
                        input bit pred);
    bus.i_ex_valid = 1; bus.i_ex_branch = br; bus.i_ex_jump = jp; bus.i_ex_func3 = f3;
    bus.i_ex_rs1 = a; bus.i_ex_rs2 = b; bus.i_ex_pc = pc; bus.i_ex_target = tgt;
    bus.i_ex_pred_taken = pred; bus.i_stall = 0;
  endtask

  task automatic issue(input bit br, input bit jp, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] pc, input logic [31:0] tgt,
                       input bit pred);
    set_ex(br, jp, f3, a, b, pc, tgt, pred);
    @(posedge clk); #1;
    idle_in();
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 0;
    @(posedge clk); #1; rst_n = 1;
  endtask

  initial begin
    idle_in();
    bus.i_if_pc = 32'h200;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    chk_en = 1;
    sample();
    check("rst_redirect", {31'd0, bus.o_redirect}, 32'd0);
    check("rst_redirect_pc", bus.o_redirect_pc, 32'd0);
    check("rst_flush", {31'd0, bus.o_flush}, 32'd0);
    check("rst_branch_cnt", bus.o_branch_cnt, 32'd0);
    check("rst_mispredict_cnt", bus.o_mispredict_cnt, 32'd0);
    check("rst_pred_taken", {31'd0, bus.o_pred_taken}, 32'd0);

    // BEQ taken but predicted not-taken
    issue(1, 0, 3'b000, 32'h5, 32'h5, 32'h100, 32'h180, 0);
    sample();
    check("beq_redirect", {31'd0, bus.o_redirect}, 32'd1);
    check("beq_redirect_pc", bus.o_redirect_pc, 32'h180);
    check("beq_flush1", {31'd0, bus.o_flush}, 32'd1);
    check("beq_mcnt", bus.o_mispredict_cnt, 32'd1);
    check("beq_bcnt", bus.o_branch_cnt, 32'd1);
    sample();
    check("beq_redirect_off", {31'd0, bus.o_redirect}, 32'd0);
    check("beq_flush2", {31'd0, bus.o_flush}, 32'd1);
    sample();
    check("beq_flush_off", {31'd0, bus.o_flush}, 32'd0);

    issue(1, 0, 3'b100, 32'hFFFF_FFFF, 32'h1, 32'h104, 32'h300, 0);
    sample();
    check("blt_neg_taken", {31'd0, bus.o_redirect}, 32'd1);
    check("blt_neg_pc", bus.o_redirect_pc, 32'h300);
    sample(); sample();
    issue(1, 0, 3'b110, 32'hFFFF_FFFF, 32'h1, 32'h108, 32'h300, 0);
    sample();
    check("bltu_not_taken", {31'd0, bus.o_redirect}, 32'd0);
    check("bltu_no_flush", {31'd0, bus.o_flush}, 32'd0);
    issue(1, 0, 3'b100, 32'd7, 32'd7, 32'h10C, 32'h300, 0);
    sample();
    check("blt_eq_not_taken", {31'd0, bus.o_redirect}, 32'd0);
    issue(1, 0, 3'b101, 32'd7, 32'd7, 32'h110, 32'h308, 0);
    sample();
    check("bge_eq_taken", {31'd0, bus.o_redirect}, 32'd1);
    check("bge_eq_pc", bus.o_redirect_pc, 32'h308);
    sample(); sample();

    // BHT training on one entry
    do_reset();
    bus.i_if_pc = 32'h200;
    sample();
    check("bht_reset_pred", {31'd0, bus.o_pred_taken}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      issue(1, 0, 3'b000, 32'd1, 32'd1, 32'h200, 32'h240, 0);
      sample(); sample(); sample();
      if (i == 0) check("bht_after_1_taken", {31'd0, bus.o_pred_taken}, 32'd1);
    end
    check("bht_after_5_taken", {31'd0, bus.o_pred_taken}, 32'd1);
    issue(1, 0, 3'b001, 32'd1, 32'd1, 32'h200, 32'h240, 0);
    sample();
    check("bht_sat_then_1_nt", {31'd0, bus.o_pred_taken}, 32'd1);
    issue(1, 0, 3'b001, 32'd1, 32'd1, 32'h200, 32'h240, 0);
    sample();
    check("bht_sat_then_2_nt", {31'd0, bus.o_pred_taken}, 32'd0);

    // JAL predicted taken, then a wrong-path branch during flush
    do_reset();
    bus.i_if_pc = 32'h400;
    issue(0, 1, 3'b000, 32'd0, 32'd0, 32'h400, 32'h800, 1);
    sample();
    check("jal_no_redirect", {31'd0, bus.o_redirect}, 32'd0);
    check("jal_no_flush", {31'd0, bus.o_flush}, 32'd0);
    check("jal_bcnt", bus.o_branch_cnt, 32'd1);
    check("jal_mcnt", bus.o_mispredict_cnt, 32'd0);
    check("jal_bht_unchanged", {31'd0, bus.o_pred_taken}, 32'd0);
    issue(1, 0, 3'b000, 32'd3, 32'd3, 32'h404, 32'h900, 0);
    issue(1, 0, 3'b001, 32'd1, 32'd2, 32'h400, 32'hA00, 0);
    sample();
    check("flush_ignored_bcnt", bus.o_branch_cnt, 32'd2);
    check("flush_ignored_mcnt", bus.o_mispredict_cnt, 32'd1);
    check("flush_ignored_redirect", {31'd0, bus.o_redirect}, 32'd0);
    check("flush_ignored_bht", {31'd0, bus.o_pred_taken}, 32'd0);
    sample(); sample();

    // Stalled mispredicting branch resolves once after release
    set_ex(1, 0, 3'b000, 32'd9, 32'd9, 32'h500, 32'h600, 0);
    bus.i_stall = 1;
    for (int i = 0; i < 3; i++) begin
      sample();
      check("stall_no_redirect", {31'd0, bus.o_redirect}, 32'd0);
    end
    bus.i_stall = 0;
    @(posedge clk); #1;
    idle_in();
    sample();
    check("stall_release_redirect", {31'd0, bus.o_redirect}, 32'd1);
    check("stall_release_pc", bus.o_redirect_pc, 32'h600);
    check("stall_release_mcnt", bus.o_mispredict_cnt, 32'd2);
    sample();
    check("stall_single_redirect", {31'd0, bus.o_redirect}, 32'd0);
    sample();

    // Async reset in the second flush cycle
    bus.i_if_pc = 32'h200;
    issue(1, 0, 3'b000, 32'd1, 32'd1, 32'h200, 32'h280, 0);
    sample();
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    check("arst_flush", {31'd0, bus.o_flush}, 32'd0);
    check("arst_redirect", {31'd0, bus.o_redirect}, 32'd0);
    check("arst_bcnt", bus.o_branch_cnt, 32'd0);
    check("arst_mcnt", bus.o_mispredict_cnt, 32'd0);
    check("arst_pred", {31'd0, bus.o_pred_taken}, 32'd0);
    @(negedge clk); #1;
    rst_n = 1;
    issue(1, 0, 3'b000, 32'd4, 32'd4, 32'h210, 32'h990, 0);
    sample();
    check("arst_idle_redirect", {31'd0, bus.o_redirect}, 32'd1);
    check("arst_idle_pc", bus.o_redirect_pc, 32'h990);
    sample(); sample();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      bus.i_ex_valid      = ($urandom_range(0, 3) != 0);
      bus.i_ex_branch     = $urandom_range(0, 1);
      bus.i_ex_jump       = ($urandom_range(0, 5) == 0);
      bus.i_ex_func3      = 3'($urandom_range(0, 7));
      bus.i_ex_rs1        = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 3)) : $urandom;
      bus.i_ex_rs2        = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 3)) : $urandom;
      bus.i_ex_pc         = {22'($urandom_range(0, 3) * 32'h100), 8'($urandom_range(0, 15) * 4), 2'b00};
      bus.i_ex_target     = $urandom;
      bus.i_ex_pred_taken = $urandom_range(0, 1);
      bus.i_stall         = ($urandom_range(0, 4) == 0);
      bus.i_if_pc         = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
    end
    @(posedge clk); #1;
    idle_in();
    sample(); sample(); sample();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
